// File: rtl/machine_csr_file.sv
// Machine-mode CSR file and trap/MRET commit unit for the RV32 core.
// Holds the M-mode CSRs and 64-bit counters, and drives the fetch redirect and interrupt request.
module machine_csr_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_en,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret_valid,
    input  logic        instret,
    input  logic        irq_external,
    input  logic        irq_timer,
    input  logic        irq_software,
    output logic        irq_pending,
    output logic [31:0] irq_cause,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        mstatus_mie
);

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

    logic        mie_bit_q, mie_bit_d;
    logic        mpie_q, mpie_d;
    logic [31:0] mie_reg_q, mie_reg_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mtval_q, mtval_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;

    logic [31:0] mip_vec;
    logic [31:0] pend_vec;
    logic [31:0] rval;
    logic        mapped;
    logic        read_only;
    logic [31:0] wval;
    logic        csr_wr;
    logic [31:0] trap_base;
    logic [31:0] trap_target;

    assign mip_vec  = {20'b0, irq_external, 3'b0, irq_timer, 3'b0, irq_software, 3'b0};
    assign pend_vec = mip_vec & mie_reg_q;

    always_comb begin
        rval      = 32'h0;
        mapped    = 1'b1;
        read_only = 1'b0;
        case (csr_addr)
            12'h300: rval = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_bit_q, 3'b0};
            12'h301: begin rval = MISA_VALUE; read_only = 1'b1; end
            12'h304: rval = mie_reg_q;
            12'h305: rval = mtvec_q;
            12'h340: rval = mscratch_q;
            12'h341: rval = mepc_q;
            12'h342: rval = mcause_q;
            12'h343: rval = mtval_q;
            12'h344: begin rval = mip_vec; read_only = 1'b1; end
            12'hB00: rval = mcycle_q[31:0];
            12'hB80: rval = mcycle_q[63:32];
            12'hB02: rval = minstret_q[31:0];
            12'hB82: rval = minstret_q[63:32];
            12'hF14: begin rval = 32'h0; read_only = 1'b1; end
            default: mapped = 1'b0;
        endcase
    end

    assign csr_illegal = csr_en && (csr_op != 2'b00) &&
                         (!mapped || (read_only && ((csr_op == OP_RW) || (csr_wdata != 32'h0))));
    assign csr_rdata   = csr_illegal ? 32'h0 : rval;

    always_comb begin
        case (csr_op)
            OP_RW:   wval = csr_wdata;
            OP_RS:   wval = rval | csr_wdata;
            OP_RC:   wval = rval & ~csr_wdata;
            default: wval = rval;
        endcase
    end

    // Trap and MRET commits own the cycle; a CSR write arriving alongside them is dropped.
    assign csr_wr = csr_en && (csr_op != 2'b00) && !csr_illegal && !trap_valid && !mret_valid;

    assign trap_base   = {mtvec_q[31:2], 2'b00};
    assign trap_target = ((mtvec_q[1:0] == 2'b01) && trap_cause[31]) ?
                         trap_base + {25'b0, trap_cause[4:0], 2'b00} : trap_base;

    always_comb begin
        mie_bit_d        = mie_bit_q;
        mpie_d           = mpie_q;
        mie_reg_d        = mie_reg_q;
        mtvec_d          = mtvec_q;
        mscratch_d       = mscratch_q;
        mepc_d           = mepc_q;
        mcause_d         = mcause_q;
        mtval_d          = mtval_q;
        mcycle_d         = mcycle_q + 64'd1;
        minstret_d       = instret ? minstret_q + 64'd1 : minstret_q;
        redirect_valid_d = trap_valid || mret_valid;
        redirect_pc_d    = redirect_pc_q;

        if (trap_valid) begin
            mepc_d        = {trap_pc[31:2], 2'b00};
            mcause_d      = trap_cause;
            mtval_d       = trap_tval;
            mpie_d        = mie_bit_q;
            mie_bit_d     = 1'b0;
            redirect_pc_d = trap_target;
        end else if (mret_valid) begin
            mie_bit_d     = mpie_q;
            mpie_d        = 1'b1;
            redirect_pc_d = mepc_q;
        end else if (csr_wr) begin
            case (csr_addr)
                12'h300: begin mie_bit_d = wval[3]; mpie_d = wval[7]; end
                12'h304: mie_reg_d  = wval & MIE_MASK;
                12'h305: mtvec_d    = {wval[31:2], wval[1] ? 2'b00 : wval[1:0]};
                12'h340: mscratch_d = wval;
                12'h341: mepc_d     = {wval[31:2], 2'b00};
                12'h342: mcause_d   = wval;
                12'h343: mtval_d    = wval;
                12'hB00: mcycle_d   = {mcycle_q[63:32], wval};
                12'hB80: mcycle_d   = {wval, mcycle_q[31:0]};
                12'hB02: minstret_d = {minstret_q[63:32], wval};
                12'hB82: minstret_d = {wval, minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_bit_q        <= 1'b0;
            mpie_q           <= 1'b0;
            mie_reg_q        <= 32'h0;
            mtvec_q          <= MTVEC_RESET;
            mscratch_q       <= 32'h0;
            mepc_q           <= 32'h0;
            mcause_q         <= 32'h0;
            mtval_q          <= 32'h0;
            mcycle_q         <= 64'h0;
            minstret_q       <= 64'h0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'h0;
        end else begin
            mie_bit_q        <= mie_bit_d;
            mpie_q           <= mpie_d;
            mie_reg_q        <= mie_reg_d;
            mtvec_q          <= mtvec_d;
            mscratch_q       <= mscratch_d;
            mepc_q           <= mepc_d;
            mcause_q         <= mcause_d;
            mtval_q          <= mtval_d;
            mcycle_q         <= mcycle_d;
            minstret_q       <= minstret_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign mstatus_mie    = mie_bit_q;
    assign irq_pending    = mie_bit_q && (pend_vec != 32'h0);

    always_comb begin
        if (pend_vec[11])     irq_cause = 32'h8000_000B;
        else if (pend_vec[3]) irq_cause = 32'h8000_0003;
        else if (pend_vec[7]) irq_cause = 32'h8000_0007;
        else                  irq_cause = 32'h0;
    end

endmodule

// File: doc/machine_csr_file.md
# machine_csr_file

Machine-mode CSR register file and trap-commit unit for the RV32 core. It is the responding end of the exception/interrupt path: it accepts trap and MRET commits from the exception handler and executes CSR instructions from the execute stage. It holds mstatus, mie, mtvec, mscratch, mepc, mcause, mtval and the 64-bit cycle/instret counters, and drives the fetch redirect and the pending-interrupt request.

## Interface
Parameters:
- MTVEC_RESET, 32'h0000_0000, mtvec value after reset (bits 1:0 must be 00 or 01).
- MISA_VALUE, 32'h4000_0100, constant read value of misa (RV32I).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- csr_en  in  1  CSR instruction valid this cycle.
- csr_op  in  2  01 RW, 10 RS (set), 11 RC (clear), 00 no-op.
- csr_addr  in  12  CSR address.
- csr_wdata  in  32  source operand.
- csr_rdata  out  32  old CSR value (combinational).
- csr_illegal  out  1  access faults (combinational).
- trap_valid  in  1  commit trap entry this cycle.
- trap_cause  in  32  mcause value; bit 31 = interrupt.
- trap_pc  in  32  faulting/interrupted PC.
- trap_tval  in  32  mtval value.
- mret_valid  in  1  commit MRET this cycle.
- instret  in  1  one instruction retired this cycle.
- irq_external, irq_timer, irq_software  in  1 each  level interrupt lines.
- irq_pending  out  1  enabled interrupt is pending (combinational).
- irq_cause  out  32  cause for the highest-priority pending interrupt.
- redirect_valid  out  1  registered, one-cycle fetch redirect.
- redirect_pc  out  32  registered redirect target.
- mstatus_mie  out  1  current global interrupt enable.

## Operation
- Map: misa 0x301 (RO), mstatus 0x300 (MIE bit 3, MPIE bit 7, MPP 12:11 reads 2'b11, other bits 0), mie 0x304 (bits 3/7/11 writable), mtvec 0x305 (bits 31:2 base, 1:0 mode; mode writes of 1x stored as 00), mscratch 0x340, mepc 0x341 (bits 1:0 forced 0), mcause 0x342, mtval 0x343, mip 0x344 (RO: bit11 ext, bit7 timer, bit3 sw), mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82, mhartid 0xF14 (RO, 0).
- New value: RW wdata; RS old|wdata; RC old&~wdata; then masked by writable bits.
- csr_illegal = csr_en & op!=00 & (unmapped address | (read-only address & (op==RW | wdata!=0))). Illegal access changes no state; csr_rdata = 0.
- Priority per cycle: trap_valid > mret_valid > CSR write. Lower-priority action that cycle is dropped entirely (CSR write not performed).
- Trap: mepc<=trap_pc&~3, mcause<=trap_cause, mtval<=trap_tval, MPIE<=MIE, MIE<=0. Target = mtvec base; if mode 01 and trap_cause[31], base + 4*trap_cause[4:0].
- MRET: MIE<=MPIE, MPIE<=1, target = mepc.
- Counters: mcycle +1 every cycle, minstret +1 when instret; 64-bit wrap to 0. CSR write of a half replaces that half and suppresses that counter's increment that cycle.
- irq: pending vector = mip & mie; irq_pending = MIE & |vector. Priority external (0x8000_000B) > software (0x8000_0003) > timer (0x8000_0007); irq_cause = 0 when none.

## Timing
- Reset: mstatus MIE/MPIE 0, mie 0, mtvec MTVEC_RESET, mscratch/mepc/mcause/mtval 0, counters 0, redirect_valid 0, redirect_pc 0.
- CSR read returns pre-write value same cycle; write visible on csr_rdata next cycle.
- redirect_valid high exactly one cycle, the cycle after trap_valid or mret_valid; redirect_pc stable with it. Back-to-back commits give back-to-back redirect pulses.
- mstatus_mie and irq_pending reflect trap/MRET updates the cycle after commit.
- Counter reads show the value before this cycle's increment.
- Reset mid-redirect clears redirect_valid immediately.

## Test plan
- Reset, read mtvec -> MTVEC_RESET; mcycle after 10 idle cycles reads 10 (±read-cycle offset exactly 10 at 11th cycle read).
- Write mtvec=0x8000_0001, MIE=1, trap_valid cause 0x8000_0007 pc 0x100 -> next cycle redirect_pc 0x8000_001C, mepc 0x100, MIE 0, MPIE 1.
- MRET after that -> redirect_pc 0x100, MIE 1, MPIE 1.
- mie=0x888, MIE=1, all irq lines high -> irq_cause 0x8000_000B; drop external -> 0x8000_0003.
- RW to mhartid -> csr_illegal 1, no change; RS mhartid wdata 0 -> legal, rdata 0; RW 0x7C0 -> illegal.
- trap_valid and CSR RW to mscratch same cycle -> trap taken, mscratch unchanged; mcycle write 0xFFFF_FFFF then wrap -> mcycleh increments.
